// File: rtl/riscv_mem_arbiter.sv
// Arbitrates the single main-memory port between I-cache refills and D-cache refill/writeback.
// Define RISCV_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module riscv_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int BEATS  = 2,
  localparam int OFS    = $clog2(BEATS * DATA_W / 8),
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              i_riscv_arb_clk,
  input  logic              i_riscv_arb_rst,
  input  logic              i_riscv_arb_ireq,
  input  logic [ADDR_W-1:0] i_riscv_arb_iaddr,
  output logic              o_riscv_arb_ivalid,
  output logic              o_riscv_arb_idone,
  input  logic              i_riscv_arb_dreq,
  input  logic              i_riscv_arb_dwe,
  input  logic [ADDR_W-1:0] i_riscv_arb_daddr,
  input  logic [DATA_W-1:0] i_riscv_arb_dwdata,
  output logic              o_riscv_arb_dvalid,
  output logic              o_riscv_arb_ddone,
  output logic [DATA_W-1:0] o_riscv_arb_rdata,
  output logic [BEAT_W-1:0] o_riscv_arb_beat,
  output logic              o_riscv_arb_busy,
  output logic              o_riscv_arb_mem_req,
  output logic              o_riscv_arb_mem_we,
  output logic [ADDR_W-1:0] o_riscv_arb_mem_addr,
  output logic [DATA_W-1:0] o_riscv_arb_mem_wdata,
  input  logic              i_riscv_arb_mem_ack,
  input  logic [DATA_W-1:0] i_riscv_arb_mem_rdata
);

  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFS) - ADDR_W'(1));
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, I_XFER, D_XFER} state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] base_addr;
  logic              we_q;
  logic [BEAT_W-1:0] beat;
  logic              grant_d;
  logic              grant_i;
  logic              xfer;
  logic              last_beat;

`ifdef RISCV_ARB_RR_EN
  // last_i set means I was served most recently, so D wins the next tie.
  logic last_i;

  always_comb begin
    grant_d = i_riscv_arb_dreq & (~i_riscv_arb_ireq | last_i);
    grant_i = i_riscv_arb_ireq & ~grant_d;
  end

  always_ff @(posedge i_riscv_arb_clk or posedge i_riscv_arb_rst) begin
    if (i_riscv_arb_rst)
      last_i <= 1'b1;
    else if (state == IDLE && (grant_d || grant_i))
      last_i <= grant_i;
  end
`else
  always_comb begin
    grant_d = i_riscv_arb_dreq;
    grant_i = i_riscv_arb_ireq & ~i_riscv_arb_dreq;
  end
`endif

  assign xfer      = (state != IDLE);
  assign last_beat = (beat == LAST_BEAT);

  always_ff @(posedge i_riscv_arb_clk or posedge i_riscv_arb_rst) begin
    if (i_riscv_arb_rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_d)
          next_state = D_XFER;
        else if (grant_i)
          next_state = I_XFER;
      end
      I_XFER, D_XFER: begin
        if (i_riscv_arb_mem_ack && last_beat)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Line base and direction are captured only at grant; beat advances on each ack.
  always_ff @(posedge i_riscv_arb_clk or posedge i_riscv_arb_rst) begin
    if (i_riscv_arb_rst) begin
      base_addr <= '0;
      we_q      <= 1'b0;
      beat      <= '0;
    end else if (state == IDLE) begin
      beat <= '0;
      if (grant_d) begin
        base_addr <= i_riscv_arb_daddr & LINE_MASK;
        we_q      <= i_riscv_arb_dwe;
      end else if (grant_i) begin
        base_addr <= i_riscv_arb_iaddr & LINE_MASK;
        we_q      <= 1'b0;
      end
    end else if (i_riscv_arb_mem_ack) begin
      beat <= last_beat ? '0 : beat + BEAT_W'(1);
    end
  end

  always_comb begin
    o_riscv_arb_busy      = xfer;
    o_riscv_arb_mem_req   = xfer;
    o_riscv_arb_mem_we    = xfer & we_q;
    o_riscv_arb_mem_addr  = '0;
    o_riscv_arb_mem_wdata = '0;
    o_riscv_arb_rdata     = '0;
    o_riscv_arb_beat      = beat;
    o_riscv_arb_ivalid    = (state == I_XFER) & i_riscv_arb_mem_ack;
    o_riscv_arb_dvalid    = (state == D_XFER) & i_riscv_arb_mem_ack;
    o_riscv_arb_idone     = o_riscv_arb_ivalid & last_beat;
    o_riscv_arb_ddone     = o_riscv_arb_dvalid & last_beat;
    if (xfer) begin
      o_riscv_arb_mem_addr  = base_addr + (ADDR_W'(beat) << BYTE_SH);
      o_riscv_arb_mem_wdata = i_riscv_arb_dwdata;
      if (i_riscv_arb_mem_ack)
        o_riscv_arb_rdata = i_riscv_arb_mem_rdata;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomized self-checking bench for riscv_mem_arbiter against a transaction-level reference model.
// Honours RISCV_ARB_RR_EN the same way the design does.
module tb_riscv_mem_arbiter;

  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int BEATS      = 2;
  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int LINE_BYTES = BEATS * BEAT_BYTES;
`ifdef RISCV_ARB_RR_EN
  localparam bit RR = 1'b1;
  localparam logic [7:0] GRANT_SEQ = 8'h99;
`else
  localparam bit RR = 1'b0;
  localparam logic [7:0] GRANT_SEQ = 8'h95;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              ireq, dreq, dwe, memAck;
  logic [ADDR_W-1:0] iaddr, daddr;
  logic [DATA_W-1:0] dwdata, memRdata;
  logic              ivalid, idone, dvalid, ddone, busy, memReq, memWe;
  logic [DATA_W-1:0] rdata, memWdata;
  logic [ADDR_W-1:0] memAddr;
  logic              beat;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: who owns the port, which beat, line base, direction, RR history.
  int                mOwner;
  int                mBeat;
  logic [ADDR_W-1:0] mBase;
  logic              mWe;
  logic              mLastI;

  logic [ADDR_W-1:0] snapAddr;
  logic              snapIvalid, snapIdone, snapDvalid, snapDdone, snapBusy, snapMemWe, snapBeat;
  logic [DATA_W-1:0] snapRdata;
  logic [7:0]        grants;

  always #5 clk = ~clk;

  riscv_mem_arbiter dut (
    .i_riscv_arb_clk       (clk),
    .i_riscv_arb_rst       (rst),
    .i_riscv_arb_ireq      (ireq),
    .i_riscv_arb_iaddr     (iaddr),
    .o_riscv_arb_ivalid    (ivalid),
    .o_riscv_arb_idone     (idone),
    .i_riscv_arb_dreq      (dreq),
    .i_riscv_arb_dwe       (dwe),
    .i_riscv_arb_daddr     (daddr),
    .i_riscv_arb_dwdata    (dwdata),
    .o_riscv_arb_dvalid    (dvalid),
    .o_riscv_arb_ddone     (ddone),
    .o_riscv_arb_rdata     (rdata),
    .o_riscv_arb_beat      (beat),
    .o_riscv_arb_busy      (busy),
    .o_riscv_arb_mem_req   (memReq),
    .o_riscv_arb_mem_we    (memWe),
    .o_riscv_arb_mem_addr  (memAddr),
    .o_riscv_arb_mem_wdata (memWdata),
    .i_riscv_arb_mem_ack   (memAck),
    .i_riscv_arb_mem_rdata (memRdata)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  task automatic modelReset();
    mOwner = 0;
    mBeat  = 0;
    mBase  = '0;
    mWe    = 1'b0;
    mLastI = 1'b1;
  endtask

  // Compares every output against what the model says for the current inputs.
  task automatic checkAll();
    bit                active;
    bit                ackHit;
    logic [ADDR_W-1:0] expAddr;
    active  = (mOwner != 0);
    ackHit  = active && memAck;
    expAddr = active ? mBase + 64'(mBeat * BEAT_BYTES) : 64'd0;
    checkOutput("busy",   64'(busy),   64'(active));
    checkOutput("memReq", 64'(memReq), 64'(active));
    checkOutput("memWe",  64'(memWe),  64'(active && mWe));
    checkOutput("memAddr", memAddr, expAddr);
    checkOutput("memWdata", memWdata, active ? dwdata : 64'd0);
    checkOutput("rdata",  rdata, ackHit ? memRdata : 64'd0);
    checkOutput("beat",   64'(beat), 64'(mBeat));
    checkOutput("ivalid", 64'(ivalid), 64'(mOwner == 1 && memAck));
    checkOutput("dvalid", 64'(dvalid), 64'(mOwner == 2 && memAck));
    checkOutput("idone",  64'(idone),  64'(mOwner == 1 && memAck && mBeat == BEATS - 1));
    checkOutput("ddone",  64'(ddone),  64'(mOwner == 2 && memAck && mBeat == BEATS - 1));
    snapAddr   = memAddr;
    snapIvalid = ivalid;
    snapIdone  = idone;
    snapDvalid = dvalid;
    snapDdone  = ddone;
    snapBusy   = busy;
    snapMemWe  = memWe;
    snapBeat   = beat;
    snapRdata  = rdata;
  endtask

  // Advances the model by one clock edge using the inputs the DUT is about to sample.
  task automatic modelStep();
    bit                pickD;
    logic [ADDR_W-1:0] a;
    if (mOwner == 0) begin
      if (dreq || ireq) begin
        pickD  = dreq && !(RR && ireq && !mLastI);
        mLastI = !pickD;
        a      = pickD ? daddr : iaddr;
        mBase  = a - (a % LINE_BYTES);
        mWe    = pickD ? dwe : 1'b0;
        mOwner = pickD ? 2 : 1;
        mBeat  = 0;
      end
    end else if (memAck) begin
      if (mBeat == BEATS - 1) begin
        mOwner = 0;
        mBeat  = 0;
      end else begin
        mBeat++;
      end
    end
  endtask

  // One cycle: drive inputs just after the edge, check mid-cycle, then step to the next edge.
  task automatic applyStimulus(input logic ir, input logic [63:0] ia, input logic dr, input logic dw,
                               input logic [63:0] da, input logic ack, input logic [63:0] rd);
    ireq     = ir;
    iaddr    = ia;
    dreq     = dr;
    dwe      = dw;
    daddr    = da;
    memAck   = ack;
    memRdata = rd;
    dwdata   = {$urandom, $urandom};
    #3;
    checkAll();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1;
    {ireq, dreq, dwe, memAck} = '0;
    iaddr = '0; daddr = '0; dwdata = '0; memRdata = '0;
    grants = '0;
    modelReset();
    @(posedge clk);
    #1;
    checkAll();
    rst = 1'b0;

    // Single I refill at 0x1008 with zero-wait memory.
    applyStimulus(1, 64'h1008, 0, 0, 0, 0, rnd64());
    applyStimulus(1, 64'h1008, 0, 0, 0, 1, 64'hA);
    checkOutput("tpI_addr0", snapAddr, 64'h1000);
    checkOutput("tpI_rdata0", snapRdata, 64'hA);
    checkOutput("tpI_idone0", 64'(snapIdone), 64'd0);
    applyStimulus(1, 64'h1008, 0, 0, 0, 1, 64'hB);
    checkOutput("tpI_addr1", snapAddr, 64'h1008);
    checkOutput("tpI_idone1", 64'(snapIdone), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, rnd64());
    checkOutput("tpI_bubble", 64'(snapBusy), 64'd0);

    // D writeback at 0x2000 with three wait states before each ack.
    applyStimulus(0, 0, 1, 1, 64'h2000, 0, rnd64());
    for (int b = 0; b < BEATS; b++) begin
      for (int w = 0; w < 3; w++) begin
        applyStimulus(0, rnd64(), 1, 0, rnd64(), 0, rnd64());
        checkOutput("tpD_waitDvalid", 64'(snapDvalid), 64'd0);
      end
      applyStimulus(0, rnd64(), 1, 0, rnd64(), 1, rnd64());
      checkOutput("tpD_we", 64'(snapMemWe), 64'd1);
      checkOutput("tpD_ddone", 64'(snapDdone), 64'(b == BEATS - 1));
    end

    // Asynchronous reset during beat 0 of a D refill, then a normal I refill.
    applyStimulus(0, 0, 1, 0, 64'h3000, 0, rnd64());
    dreq = 1'b0;
    memAck = 1'b1;
    memRdata = rnd64();
    #1;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1, 64'h4010, 0, 0, 0, 0, rnd64());
    applyStimulus(0, 0, 0, 0, 0, 1, rnd64());
    checkOutput("tpR_addr0", snapAddr, 64'h4010);
    applyStimulus(0, 0, 0, 0, 0, 1, rnd64());
    checkOutput("tpR_idone", 64'(snapIdone), 64'd1);

    // Simultaneous requests: grant order is recorded at each beat-0 ack.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, rnd64(), (RR || k < 3), 0, rnd64(), 1, rnd64());
      if ((snapIvalid || snapDvalid) && snapBeat == 1'b0)
        grants = {grants[5:0], snapDvalid ? 2'b10 : 2'b01};
    end
    checkOutput("tpS_grantSeq", 64'(grants), 64'(GRANT_SEQ));
    applyStimulus(0, 0, 0, 0, 0, 0, rnd64());

    // Stray ack in IDLE, then ireq dropped right after the grant.
    applyStimulus(0, 0, 0, 0, 0, 1, rnd64());
    checkOutput("tpX_strayIvalid", 64'(snapIvalid | snapDvalid), 64'd0);
    applyStimulus(1, 64'h5000, 0, 0, 0, 0, rnd64());
    applyStimulus(0, 0, 0, 0, 0, 1, rnd64());
    applyStimulus(0, 0, 0, 0, 0, 1, rnd64());
    checkOutput("tpX_idone", 64'(snapIdone), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, rnd64());
    checkOutput("tpX_idle", 64'(snapBusy), 64'd0);

    // Random traffic: requests, addresses and acks all change freely.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom % 2) == 0, rnd64(), ($urandom % 5) < 2, $urandom % 2,
                    rnd64(), ($urandom % 5) < 3, rnd64());
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
